// File: rtl/rf_pkg.sv
// Shared constants and helpers for the register-file writeback arbiter.
package rf_pkg;

   localparam int RF_ADDR_W   = 4;
   localparam int RF_INT_REGS = 8;
   localparam int RF_RNS_BIT  = 3;
   localparam int RF_REGS     = 2 * RF_INT_REGS;

   localparam int REQ_ALU = 0;
   localparam int REQ_RNS = 1;
   localparam int REQ_LD  = 2;

   // True when the destination lives in the RNS half of the register file.
   function automatic logic rf_is_rns(input logic [RF_ADDR_W-1:0] addr);
      return addr[RF_RNS_BIT];
   endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin grant. The search starts just after the last
// granted index and wraps; the pointer itself is held by the parent.
module rr_arbiter3 (
   input  logic [2:0] req_valid,
   input  logic [1:0] rr_last,
   output logic [2:0] grant,
   output logic [1:0] grant_idx,
   output logic       grant_valid
);

   logic [1:0] idx;

   function automatic logic [1:0] next3(input logic [1:0] i);
      return (i >= 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

   // Walk the three candidates in rotated order and take the first valid one.
   always_comb begin
      // NOTE: every output gets a default before any branch, otherwise a path
      // that leaves it unassigned would infer a latch.
      grant     = '0;
      grant_idx = 2'd0;
      idx       = next3(rr_last);
      for (int k = 0; k < 3; k++) begin
         if (grant == 3'b000 && req_valid[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
         idx = next3(idx);
      end
   end

   assign grant_valid = |grant;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the single register-file write port, with a
// pending-write scoreboard used by issue to stall on RAW/WAW hazards.
module rf_wb_arbiter
   import rf_pkg::*;
#(
   parameter int NUM_DOMAINS = 1,
   parameter int NUM_REQ     = 3,
   localparam int DW         = NUM_DOMAINS * 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*RF_ADDR_W-1:0]  req_addr,
   input  logic [NUM_REQ*DW-1:0]         req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          alloc_valid,
   input  logic [RF_ADDR_W-1:0]          alloc_addr,
   output logic                          alloc_ready,
   input  logic [RF_ADDR_W-1:0]          chk_addr1,
   input  logic [RF_ADDR_W-1:0]          chk_addr2,
   output logic                          chk_busy,
   output logic                          wr_en,
   output logic [RF_ADDR_W-1:0]          wr_addr,
   output logic [DW-1:0]                 wr_data,
   output logic                          wr_RNS,
   output logic [RF_REGS-1:0]            busy,
   output logic                          err_unalloc
);

   logic [1:0]           rr_last;
   logic [2:0]           grant;
   logic [1:0]           grant_idx;
   logic                 transfer;
   logic [RF_ADDR_W-1:0] win_addr;
   logic [DW-1:0]        win_data;
   logic                 alloc_set;
   logic                 alloc_hits_write;

   rr_arbiter3 u_arb (
      .req_valid   (req_valid),
      .rr_last     (rr_last),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (transfer)
   );

   assign req_ready = grant;

   // Select the winner's address and data; grant is one-hot or zero.
   always_comb begin
      win_addr = '0;
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            win_addr = req_addr[i*RF_ADDR_W +: RF_ADDR_W];
            win_data = req_data[i*DW +: DW];
         end
      end
   end

   // Round-robin pointer moves only when a transfer happens.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (reset)         rr_last <= 2'd2;
      else if (transfer) rr_last <= grant_idx;
   end

   // Output register driving the register-file write port; address and data
   // hold when idle, only the enable drops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         wr_RNS  <= 1'b0;
      end else begin
         wr_en <= transfer;
         if (transfer) begin
            wr_addr <= win_addr;
            wr_data <= win_data;
            wr_RNS  <= rf_is_rns(win_addr);
         end
      end
   end

   assign alloc_ready      = ~busy[alloc_addr];
   assign alloc_set        = alloc_valid & alloc_ready;
   assign chk_busy         = busy[chk_addr1] | busy[chk_addr2];
   assign alloc_hits_write = alloc_set & wr_en & (alloc_addr == wr_addr);

   // Scoreboard: clear on the committing write, then apply the claim so a
   // same-address set overrides the clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy <= '0;
      end else begin
         logic [RF_REGS-1:0] busy_n;
         busy_n = busy;
         if (wr_en)     busy_n[wr_addr]    = 1'b0;
         if (alloc_set) busy_n[alloc_addr] = 1'b1;
         busy <= busy_n;
      end
   end

   // Flag a committed write to a register nobody claimed. A write that lands
   // in the same cycle the register is being claimed is paired with that
   // claim and is not reported.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) err_unalloc <= 1'b0;
      else       err_unalloc <= wr_en & ~busy[wr_addr] & ~alloc_hits_write;
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter.
module tb_rf_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  req_valid;
   logic [11:0] req_addr;
   logic [23:0] req_data;
   logic [2:0]  req_ready;
   logic        alloc_valid;
   logic [3:0]  alloc_addr;
   logic        alloc_ready;
   logic [3:0]  chk_addr1;
   logic [3:0]  chk_addr2;
   logic        chk_busy;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [7:0]  wr_data;
   logic        wr_RNS;
   logic [15:0] busy;
   logic        err_unalloc;

   int n_cmp  = 0;
   int n_fail = 0;

   rf_wb_arbiter #(.NUM_DOMAINS(1), .NUM_REQ(3)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .alloc_valid (alloc_valid),
      .alloc_addr  (alloc_addr),
      .alloc_ready (alloc_ready),
      .chk_addr1   (chk_addr1),
      .chk_addr2   (chk_addr2),
      .chk_busy    (chk_busy),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_RNS      (wr_RNS),
      .busy        (busy),
      .err_unalloc (err_unalloc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] rr_addr [3];
      rr_addr[0] = 4'h1;
      rr_addr[1] = 4'h9;
      rr_addr[2] = 4'h2;

      reset       = 1'b1;
      req_valid   = 3'b000;
      req_addr    = '0;
      req_data    = '0;
      alloc_valid = 1'b0;
      alloc_addr  = 4'h0;
      chk_addr1   = 4'h0;
      chk_addr2   = 4'h0;
      #1;
      check("rst_wr_en", wr_en, 0);
      check("rst_busy", busy, 16'h0000);
      check("rst_err", err_unalloc, 0);
      check("rst_wr_addr", wr_addr, 0);
      tick();
      tick();
      reset = 1'b0;

      // Single write: claim r3, ALU writes 0x5A.
      alloc_valid = 1'b1;
      alloc_addr  = 4'h3;
      #1;
      check("t1_alloc_ready", alloc_ready, 1);
      tick();
      alloc_valid = 1'b0;
      check("t1_busy_set", busy, 16'h0008);
      req_valid = 3'b001;
      req_addr  = {4'h0, 4'h0, 4'h3};
      req_data  = {8'h00, 8'h00, 8'h5A};
      #1;
      check("t1_req_ready", req_ready, 3'b001);
      tick();
      req_valid = 3'b000;
      check("t1_wr_en", wr_en, 1);
      check("t1_wr_addr", wr_addr, 4'h3);
      check("t1_wr_rns", wr_RNS, 0);
      check("t1_wr_data", wr_data, 8'h5A);
      check("t1_busy_held", busy, 16'h0008);
      tick();
      check("t1_wr_en_off", wr_en, 0);
      check("t1_busy_clear", busy, 16'h0000);
      check("t1_err", err_unalloc, 0);

      // Reset between edges so the pointer restarts at requester 0.
      reset = 1'b1;
      #1;
      reset = 1'b0;

      // Round robin with all three requesters valid.
      for (int i = 0; i < 3; i++) begin
         alloc_valid = 1'b1;
         alloc_addr  = rr_addr[i];
         tick();
      end
      alloc_valid = 1'b0;
      check("t2_busy_alloc", busy, 16'h0206);
      req_valid = 3'b111;
      req_addr  = {rr_addr[2], rr_addr[1], rr_addr[0]};
      req_data  = {8'h33, 8'h22, 8'h11};
      for (int i = 0; i < 6; i++) begin
         #1;
         check($sformatf("t2_grant%0d", i), req_ready, 3'b001 << (i % 3));
         tick();
         check($sformatf("t2_wr_en%0d", i), wr_en, 1);
         check($sformatf("t2_wr_addr%0d", i), wr_addr, rr_addr[i % 3]);
      end
      req_valid = 3'b000;
      #1;
      check("t2_idle_ready", req_ready, 3'b000);
      tick();
      check("t2_wr_en_off", wr_en, 0);
      check("t2_wr_addr_hold", wr_addr, 4'h2);
      check("t2_busy_empty", busy, 16'h0000);

      // Hazard on RNS register 0xA.
      alloc_valid = 1'b1;
      alloc_addr  = 4'hA;
      chk_addr1   = 4'hA;
      chk_addr2   = 4'h0;
      #1;
      check("t3_alloc_ready", alloc_ready, 1);
      check("t3_chk_free", chk_busy, 0);
      tick();
      check("t3_busy_set", busy, 16'h0400);
      check("t3_chk_busy", chk_busy, 1);
      check("t3_waw_ready", alloc_ready, 0);
      tick();
      alloc_valid = 1'b0;
      check("t3_waw_nochange", busy, 16'h0400);
      req_valid = 3'b010;
      req_addr  = {4'h0, 4'hA, 4'h0};
      req_data  = {8'h00, 8'hC3, 8'h00};
      #1;
      check("t3_req_ready", req_ready, 3'b010);
      tick();
      req_valid = 3'b000;
      check("t3_wr_en", wr_en, 1);
      check("t3_wr_addr", wr_addr, 4'hA);
      check("t3_wr_rns", wr_RNS, 1);
      check("t3_wr_data", wr_data, 8'hC3);
      check("t3_chk_during_wr", chk_busy, 1);
      tick();
      check("t3_chk_after", chk_busy, 0);
      check("t3_busy_clear", busy, 16'h0000);
      check("t3_err", err_unalloc, 0);

      // Set/clear collision on r5.
      req_valid = 3'b001;
      req_addr  = {4'h0, 4'h0, 4'h5};
      req_data  = {8'h00, 8'h00, 8'h55};
      #1;
      check("t4_req_ready", req_ready, 3'b001);
      tick();
      req_valid   = 3'b000;
      alloc_valid = 1'b1;
      alloc_addr  = 4'h5;
      #1;
      check("t4_wr_en", wr_en, 1);
      check("t4_alloc_ready", alloc_ready, 1);
      tick();
      alloc_valid = 1'b0;
      check("t4_busy", busy, 16'h0020);
      check("t4_err", err_unalloc, 0);

      // Unallocated load-path write to r7.
      req_valid = 3'b100;
      req_addr  = {4'h7, 4'h0, 4'h0};
      req_data  = {8'h77, 8'h00, 8'h00};
      #1;
      check("t5_req_ready", req_ready, 3'b100);
      tick();
      req_valid = 3'b000;
      check("t5_wr_en", wr_en, 1);
      check("t5_wr_addr", wr_addr, 4'h7);
      check("t5_wr_data", wr_data, 8'h77);
      check("t5_err_pre", err_unalloc, 0);
      tick();
      check("t5_err_pulse", err_unalloc, 1);
      check("t5_wr_en_off", wr_en, 0);
      tick();
      check("t5_err_end", err_unalloc, 0);

      // Async reset while a write to r8 is on the port and busy = 0x0104.
      alloc_valid = 1'b1;
      alloc_addr  = 4'h2;
      tick();
      alloc_addr  = 4'h8;
      tick();
      alloc_valid = 1'b0;
      check("t6_busy_pre", busy, 16'h0124);
      req_valid = 3'b001;
      req_addr  = {4'h0, 4'h8, 4'h5};
      req_data  = {8'h00, 8'h88, 8'h55};
      tick();
      req_valid = 3'b010;
      #1;
      check("t6_req_ready", req_ready, 3'b010);
      tick();
      req_valid = 3'b000;
      check("t6_wr_en", wr_en, 1);
      check("t6_wr_addr", wr_addr, 4'h8);
      check("t6_busy", busy, 16'h0104);
      #2;
      reset = 1'b1;
      #1;
      check("t6_rst_wr_en", wr_en, 0);
      check("t6_rst_busy", busy, 16'h0000);
      check("t6_rst_wr_addr", wr_addr, 4'h0);
      #1;
      reset     = 1'b0;
      req_valid = 3'b111;
      req_addr  = {4'h6, 4'hB, 4'h4};
      req_data  = {8'h66, 8'hBB, 8'h44};
      #1;
      check("t6_first_grant", req_ready, 3'b001);
      tick();
      req_valid = 3'b000;
      check("t6_post_wr_en", wr_en, 1);
      check("t6_post_wr_addr", wr_addr, 4'h4);
      check("t6_post_wr_data", wr_data, 8'h44);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
